// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared channel state encoding and default parameters for the
//                multi-channel DMA write engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam int DEF_SZ    = 8;
    localparam int DEF_WSZ   = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } ch_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dma_fifo
//  Description : Per-channel word buffer. Pointers carry one extra wrap bit so
//                full and empty are distinguishable; push and pop may occur in
//                the same cycle at any occupancy. flush empties the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_fifo #(
    parameter int WSZ   = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           push,
    input  logic           pop,
    input  logic [WSZ-1:0] din,
    output logic           full,
    output logic           empty,
    output logic [WSZ-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [WSZ-1:0] mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    // A pop frees a slot in the same cycle, so a push into a full FIFO is fine then
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer update; flush wins over any concurrent push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/dma_mc.sv
`default_nettype none
// ============================================================================
//  Module      : dma_mc
//  Description : Multi-channel DMA write engine. Each channel is programmed
//                with a RAM base and word count, buffers incoming words in its
//                own FIFO and is drained to RAM by a round-robin arbiter that
//                issues at most one registered RAM write per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_mc
    import dma_pkg::*;
#(
    parameter int SZ    = DEF_SZ,
    parameter int WSZ   = DEF_WSZ,
    parameter int NCH   = DEF_NCH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(NCH)-1:0]   cfg_ch,
    input  logic [SZ-1:0]            cfg_base,
    input  logic [SZ-1:0]            cfg_len,
    output logic                     cfg_err,
    input  logic                     io_valid,
    input  logic [$clog2(NCH)-1:0]   io_ch,
    input  logic [WSZ-1:0]           io_data,
    output logic                     io_ready,
    output logic [SZ-1:0]            ram_addr,
    output logic [WSZ-1:0]           ram_wdata,
    output logic                     ram_w_notr,
    output logic [NCH-1:0]           cpu_rx_interrupt,
    input  logic [NCH-1:0]           irq_clr,
    output logic [NCH-1:0]           busy
);

    localparam int CH_W = $clog2(NCH);

    ch_state_e       state   [NCH];
    logic [SZ-1:0]   base    [NCH];
    logic [SZ-1:0]   len     [NCH];
    logic [SZ-1:0]   acc_cnt [NCH];
    logic [SZ-1:0]   wr_cnt  [NCH];
    logic [WSZ-1:0]  head    [NCH];
    logic [NCH-1:0]  full, empty, push, pop, cfg_acc, last, irq_set;
    logic            cfg_err_nx;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_vld;

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            dma_fifo #(.WSZ(WSZ), .DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .flush (cfg_acc[g]),
                .push  (push[g]),
                .pop   (pop[g]),
                .din   (io_data),
                .full  (full[g]),
                .empty (empty[g]),
                .head  (head[g])
            );
        end
    endgenerate

    // Input handshake, programming decode and busy flags per channel
    always_comb begin
        io_ready   = 1'b0;
        cfg_err_nx = 1'b0;
        push       = '0;
        cfg_acc    = '0;
        busy       = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state[i] == ACTIVE);
            if (io_ch == CH_W'(i))
                io_ready = (state[i] == ACTIVE) && !full[i] && (acc_cnt[i] < len[i]);
            if (cfg_we && cfg_ch == CH_W'(i)) begin
                if (state[i] == ACTIVE) cfg_err_nx = 1'b1;
                else                    cfg_acc[i] = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++)
            push[i] = io_valid && io_ready && (io_ch == CH_W'(i));
    end

    // Round-robin search from the pointer over active channels holding data
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        pop     = '0;
        last    = '0;
        irq_set = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!gnt_vld && !empty[idx] && state[idx] == ACTIVE) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            pop[i]     = gnt_vld && (gnt_idx == CH_W'(i));
            last[i]    = pop[i] && ((wr_cnt[i] + SZ'(1)) == len[i]);
            irq_set[i] = last[i] || (cfg_acc[i] && cfg_len == '0);
        end
    end

    // Channel registers, arbiter pointer, RAM port and interrupt flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                state[i]   <= IDLE;
                base[i]    <= '0;
                len[i]     <= '0;
                acc_cnt[i] <= '0;
                wr_cnt[i]  <= '0;
            end
            rr_ptr           <= '0;
            ram_addr         <= '0;
            ram_wdata        <= '0;
            ram_w_notr       <= 1'b0;
            cpu_rx_interrupt <= '0;
            cfg_err          <= 1'b0;
        end else begin
            cfg_err          <= cfg_err_nx;
            ram_w_notr       <= 1'b0;
            // A set in the same cycle as a clear leaves the flag set
            cpu_rx_interrupt <= (cpu_rx_interrupt & ~irq_clr) | irq_set;
            for (int i = 0; i < NCH; i++) begin
                if (cfg_acc[i]) begin
                    if (cfg_len != '0) begin
                        state[i]   <= ACTIVE;
                        base[i]    <= cfg_base;
                        len[i]     <= cfg_len;
                        acc_cnt[i] <= '0;
                        wr_cnt[i]  <= '0;
                    end else begin
                        state[i]   <= DONE;
                    end
                end else begin
                    if (push[i]) acc_cnt[i] <= acc_cnt[i] + SZ'(1);
                    if (pop[i])  wr_cnt[i]  <= wr_cnt[i] + SZ'(1);
                    if (last[i]) state[i]   <= DONE;
                end
            end
            if (gnt_vld) begin
                ram_addr   <= base[gnt_idx] + wr_cnt[gnt_idx];
                ram_wdata  <= head[gnt_idx];
                ram_w_notr <= 1'b1;
                rr_ptr     <= CH_W'((int'(gnt_idx) + 1) % NCH);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dma_mc.md
DMA_MC -- requirements
Module: dma_mc

Interface
REQ-001 SHALL take parameter SZ, default 8, address width in bits.
REQ-002 SHALL take parameter WSZ, default 8, data word width in bits.
REQ-003 SHALL take parameter NCH, default 4, number of independent channels (NCH >= 2).
REQ-004 SHALL take parameter DEPTH, default 4, per-channel FIFO depth in words (power of two, >= 2); CH_W = $clog2(NCH).
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on posedge; rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: cfg_we  in  1  program strobe; cfg_ch  in  CH_W  target channel; cfg_base  in  SZ  RAM start address; cfg_len  in  SZ  transfer length in words.
REQ-007 SHALL have ports: cfg_err  out  1  one-cycle pulse, program rejected.
REQ-008 SHALL have ports: io_valid  in  1  word offered; io_ch  in  CH_W  channel tag; io_data  in  WSZ  payload; io_ready  out  1  word accepted this cycle.
REQ-009 SHALL have ports: ram_addr  out  SZ; ram_wdata  out  WSZ; ram_w_notr  out  1  RAM write strobe, all registered.
REQ-010 SHALL have ports: cpu_rx_interrupt  out  NCH  sticky per-channel done flag; irq_clr  in  NCH  per-channel clear; busy  out  NCH  channel ACTIVE.

Function
REQ-011 Each channel SHALL have states IDLE, ACTIVE, DONE, with a base register, length register, accept counter and write counter, each SZ bits.
REQ-012 Transitions: cfg_we in IDLE/DONE with cfg_len>0 -> ACTIVE (latch base/len, clear counters, flush FIFO); with cfg_len=0 -> DONE, irq bit set at same edge.
REQ-013 cfg_we to an ACTIVE channel SHALL be ignored; cfg_err SHALL pulse high for exactly the following cycle.
REQ-014 io_ready SHALL be combinational: high iff channel io_ch is ACTIVE, its FIFO is not full, and its accept counter < len; the word is accepted at the edge when io_valid & io_ready.
REQ-015 Words beyond len, or for non-ACTIVE channels, SHALL never be accepted (io_ready=0).
REQ-016 Arbiter: one RAM write per cycle maximum; round-robin among channels with non-empty FIFO, starting from the pointer; pointer resets to 0 and moves to granted+1 mod NCH after each grant.
REQ-017 On grant SHALL register ram_addr = base + write counter (mod 2^SZ, wrap permitted), ram_wdata = FIFO head, ram_w_notr = 1; ram_w_notr = 0 in cycles without a grant.
REQ-018 Latency: a word accepted at edge k SHALL at the earliest be driven to RAM after edge k+1 (full FIFO throughput of 1 word/cycle aggregate).
REQ-019 On the grant of a channel's last word (write counter reaches len), the channel SHALL enter DONE and its cpu_rx_interrupt bit SHALL set at the same edge.
REQ-020 irq_clr[i] SHALL clear bit i at the next edge; simultaneous set and clear SHALL leave the bit set.
REQ-021 Simultaneous cfg_we to a DONE channel and its irq_clr SHALL both take effect (reprogrammed, bit cleared).
REQ-022 FIFO full: io_ready low, no loss; FIFO empty: channel not eligible for grant; simultaneous push and pop on the same FIFO SHALL be legal at any occupancy.

Reset
REQ-023 rst low SHALL immediately force: all channels IDLE, counters and FIFO pointers 0, arbiter pointer 0, ram_addr=0, ram_wdata=0, ram_w_notr=0, cpu_rx_interrupt=0, cfg_err=0; busy=0 and io_ready=0 follow.
REQ-024 Reset mid-transfer SHALL discard buffered words; no RAM write SHALL occur until reprogramming after rst deasserts.

Structure
REQ-025 Package dma_pkg SHALL hold the channel state enum (IDLE, ACTIVE, DONE) and the default parameter constants.
REQ-026 Per-channel buffering SHALL be one sub-module, dma_fifo (params WSZ, DEPTH; push, pop, full, empty, head data), instantiated NCH times.

Verification
REQ-027 Program ch0 base=0x10 len=3; send 0xA1,0xA2,0xA3 -> writes 0x10=A1, 0x11=A2, 0x12=A3 in order; cpu_rx_interrupt=0001 on third write; busy[0] falls.
REQ-028 Program ch1 base=0xFE len=4; send 4 words -> addresses 0xFE,0xFF,0x00,0x01 (wrap).
REQ-029 Program ch0..ch3 len=2 each, preload all FIFOs -> grants in order ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3 on 8 consecutive cycles.
REQ-030 Ch2 len=6, hold off arbitration by saturating others; offer 6 words -> io_ready low after DEPTH=4 buffered; all 6 eventually written, none dropped; 7th offered word refused.
REQ-031 cfg_we to ACTIVE ch0 -> cfg_err one-cycle pulse, base unchanged; cfg_len=0 to ch3 -> irq bit 3 set next edge, no RAM write.
REQ-032 Assert rst after 2 of 5 words of ch0 written -> all outputs 0 immediately; no further writes; reprogram completes correctly.
